// File: rtl/screen_buffer_pkg.sv
// Shared types and constants for the screen buffer and display controller.
// Holds the fill FSM state enum, the default geometry and the lane slice helper.
package screen_buffer_pkg;

    localparam int unsigned SB_DEPTH  = 2400;
    localparam int unsigned SB_DATA_W = 32;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_RUN,
        FILL_DONE
    } fill_state_t;

    // Big-endian lanes: lane 0 is the most significant byte of the word.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned data_w);
        return data_w - 8 * (lane + 1);
    endfunction

endpackage

// File: rtl/screen_buffer_fill.sv
// Hardware fill engine: walks every word of the buffer writing a latched value.
// Stalls (pointer holds) whenever the RAM write port is taken by CPU traffic.
module screen_buffer_fill
    import screen_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = SB_DATA_W,
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned IDX_W  = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    input  logic              stall,
    output logic              req,
    output logic [IDX_W-1:0]  addr,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    fill_state_t       state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [DATA_W-1:0] val, val_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL_IDLE;
            ptr   <= '0;
            val   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            val   <= val_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        val_nxt   = val;
        req       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        addr      = ptr;
        data      = val;
        unique case (state)
            FILL_IDLE: begin
                if (start) begin
                    val_nxt   = value;
                    ptr_nxt   = '0;
                    state_nxt = FILL_RUN;
                end
            end
            FILL_RUN: begin
                req  = 1'b1;
                busy = 1'b1;
                if (!stall) begin
                    if (ptr == LAST) state_nxt = FILL_DONE;
                    else             ptr_nxt   = ptr + 1'b1;
                end
            end
            FILL_DONE: begin
                done      = 1'b1;
                state_nxt = FILL_IDLE;
            end
            default: state_nxt = FILL_IDLE;
        endcase
    end

endmodule

// File: rtl/screen_buffer.sv
// Dual-port screen memory: CPU word/byte writes plus fill engine on port A, display reads on port B.
// Optional CPU readback on port A is enabled by defining SCREEN_BUFFER_RDBACK_EN.
module screen_buffer
  import screen_buffer_pkg::*;
#(
  parameter int unsigned DATA_W    = SB_DATA_W,
  parameter int unsigned DEPTH     = SB_DEPTH,
  parameter int unsigned ADDR_W    = 16,
  parameter string       INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W+1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [DATA_W-1:0] cpu_wdata,
`ifdef SCREEN_BUFFER_RDBACK_EN
  input  logic              cpu_rd,
  output logic [DATA_W-1:0] cpu_rdata,
`endif
  output logic              wr_err,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] cpu_idx;
  logic [1:0]        cpu_lane;
  logic              cpu_ok, disp_ok, rd_acc, stall;
  logic              fill_req;
  logic [IDX_W-1:0]  fill_addr;
  logic [DATA_W-1:0] fill_data;

  assign cpu_idx  = cpu_addr[ADDR_W+1:2];
  assign cpu_lane = cpu_addr[1:0];
  assign cpu_ok   = {1'b0, cpu_idx} < DEPTH_W;
  assign disp_ok  = {1'b0, disp_addr} < DEPTH_W;
  // Any CPU access, even a dropped out-of-range write, owns port A for the cycle.
  assign stall    = cpu_we | rd_acc;

  screen_buffer_fill #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_fill (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (fill_start),
    .value   (fill_value),
    .stall   (stall),
    .req     (fill_req),
    .addr    (fill_addr),
    .data    (fill_data),
    .busy    (fill_busy),
    .done    (fill_done)
  );

  always_ff @(posedge clock) begin
    if (cpu_we) begin
      if (cpu_ok) begin
        if (cpu_byte)
          mem[cpu_idx[IDX_W-1:0]][lane_lsb(32'(cpu_lane), DATA_W) +: 8] <= cpu_wdata[7:0];
        else
          mem[cpu_idx[IDX_W-1:0]] <= cpu_wdata;
      end
    end else if (fill_req && !stall) begin
      mem[fill_addr] <= fill_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_data <= '0;
      wr_err    <= 1'b0;
    end else begin
      disp_data <= disp_ok ? mem[disp_addr[IDX_W-1:0]] : '0;
      wr_err    <= cpu_we & ~cpu_ok;
    end
  end

`ifdef SCREEN_BUFFER_RDBACK_EN
  assign rd_acc = cpu_rd & ~cpu_we;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cpu_rdata <= '0;
    else if (rd_acc)
      cpu_rdata <= cpu_ok ? mem[cpu_idx[IDX_W-1:0]] : '0;
  end
`else
  assign rd_acc = 1'b0;
`endif

endmodule

// File: tb/tb_screen_buffer.sv
// Directed self-checking bench for screen_buffer (default build, DEPTH 2400, DATA_W 32).
module tb_screen_buffer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [17:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_byte;
    logic [31:0] cpu_wdata;
    logic        wr_err;
    logic [15:0] disp_addr;
    logic [31:0] disp_data;
    logic        fill_start;
    logic [31:0] fill_value;
    logic        fill_busy;
    logic        fill_done;
`ifdef SCREEN_BUFFER_RDBACK_EN
    logic        cpu_rd = 1'b0;
    logic [31:0] cpu_rdata;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    logic seen_done;

    always #5 clock = ~clock;

    screen_buffer #(
        .DATA_W (32),
        .DEPTH  (2400),
        .ADDR_W (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_byte   (cpu_byte),
        .cpu_wdata  (cpu_wdata),
`ifdef SCREEN_BUFFER_RDBACK_EN
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
`endif
        .wr_err     (wr_err),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_word(input string tag, input logic [15:0] a, input logic [31:0] exp);
        disp_addr = a;
        tick();
        check(tag, disp_data, exp);
    endtask

    task automatic cpu_write(input logic [17:0] a, input logic byt, input logic [31:0] d);
        cpu_addr  = a;
        cpu_byte  = byt;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        cpu_addr   = '0;
        cpu_we     = 1'b0;
        cpu_byte   = 1'b0;
        cpu_wdata  = '0;
        disp_addr  = '0;
        fill_start = 1'b0;
        fill_value = '0;
        tick();
        tick();
        check("rst_disp_data", disp_data, 32'h0);
        check("rst_wr_err", {31'b0, wr_err}, 32'h0);
        check("rst_fill_busy", {31'b0, fill_busy}, 32'h0);
        check("rst_fill_done", {31'b0, fill_done}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Plain fill of 0x20: busy N+1..N+2400, done at N+2401.
        fill_value = 32'h0000_0020;
        fill_start = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
            fill_start = 1'b0;
            if (cyc == 1) check("fill1_busy_n1", {31'b0, fill_busy}, 32'h1);
            if (fill_busy && fill_done) check("fill1_overlap", 32'h1, 32'h0);
        end while (fill_busy && cyc < 3000);
        check("fill1_busy_end_cycle", cyc, 2401);
        check("fill1_done_pulse", {31'b0, fill_done}, 32'h1);
        tick();
        check("fill1_done_clear", {31'b0, fill_done}, 32'h0);
        rd_word("fill1_w0", 16'd0, 32'h0000_0020);
        rd_word("fill1_w1199", 16'd1199, 32'h0000_0020);
        rd_word("fill1_w2399", 16'd2399, 32'h0000_0020);

        // Word write with a same-cycle display read: old data first, new data next.
        disp_addr = 16'd4;
        cpu_write(18'h10, 1'b0, 32'hDEAD_BEEF);
        check("word_read_first", disp_data, 32'h0000_0020);
        check("word_no_err", {31'b0, wr_err}, 32'h0);
        tick();
        check("word_write_4", disp_data, 32'hDEAD_BEEF);

        // Big-endian byte lanes.
        cpu_write(18'h20, 1'b1, 32'hFFFF_FF11);
        cpu_write(18'h21, 1'b1, 32'hFFFF_FF22);
        cpu_write(18'h22, 1'b1, 32'hFFFF_FF33);
        cpu_write(18'h23, 1'b1, 32'hFFFF_FF44);
        rd_word("bytes_w8", 16'd8, 32'h1122_3344);
        cpu_write(18'h25, 1'b1, 32'h0000_00AB);
        rd_word("byte_lane1_w9", 16'd9, 32'h00AB_0020);

        // Out-of-range write at word 2400.
        cpu_write(18'd9600, 1'b0, 32'hCAFE_F00D);
        check("oor_wr_err_pulse", {31'b0, wr_err}, 32'h1);
        tick();
        check("oor_wr_err_clear", {31'b0, wr_err}, 32'h0);
        rd_word("oor_disp_2400", 16'd2400, 32'h0);
        rd_word("oor_w2399_kept", 16'd2399, 32'h0000_0020);
        rd_word("oor_w0_kept", 16'd0, 32'h0000_0020);

        // Fill with 3 CPU stall cycles and an ignored mid-fill fill_start.
        fill_value = 32'h55AA_55AA;
        fill_start = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
            fill_start = 1'b0;
            cpu_we     = 1'b0;
            cpu_byte   = 1'b0;
            if (cyc == 10) begin cpu_we = 1'b1; cpu_addr = 18'd12;   cpu_wdata = 32'h1234_5678; end
            if (cyc == 20) begin cpu_we = 1'b1; cpu_addr = 18'd8000; cpu_wdata = 32'h9999_9999; end
            if (cyc == 30) begin cpu_we = 1'b1; cpu_addr = 18'd2000; cpu_wdata = 32'h7777_0000; end
            if (cyc == 50) begin fill_start = 1'b1; fill_value = 32'h0BAD_BEEF; end
        end while (fill_busy && cyc < 3000);
        cpu_we     = 1'b0;
        fill_start = 1'b0;
        check("fill2_busy_end_cycle", cyc, 2404);
        check("fill2_done_pulse", {31'b0, fill_done}, 32'h1);
        rd_word("fill2_w3_cpu_kept", 16'd3, 32'h1234_5678);
        rd_word("fill2_w2000_overwritten", 16'd2000, 32'h55AA_55AA);
        rd_word("fill2_w500_overwritten", 16'd500, 32'h55AA_55AA);
        rd_word("fill2_w9_after_stall", 16'd9, 32'h55AA_55AA);
        rd_word("fill2_w2399", 16'd2399, 32'h55AA_55AA);

        // Reset in fill cycle 100: words 0..98 new, 99 onwards untouched.
        disp_addr  = 16'd3;
        fill_value = 32'h7777_7777;
        fill_start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            fill_start = 1'b0;
        end
        check("abort_busy_before", {31'b0, fill_busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("abort_busy_now", {31'b0, fill_busy}, 32'h0);
        check("abort_disp_cleared", disp_data, 32'h0);
        tick();
        reset_n   = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fill_done || fill_busy) seen_done = 1'b1;
        end
        check("abort_no_done", {31'b0, seen_done}, 32'h0);
        rd_word("abort_w3_new", 16'd3, 32'h7777_7777);
        rd_word("abort_w98_new", 16'd98, 32'h7777_7777);
        rd_word("abort_w99_old", 16'd99, 32'h55AA_55AA);
        rd_word("abort_w100_old", 16'd100, 32'h55AA_55AA);
        rd_word("abort_w2399_old", 16'd2399, 32'h55AA_55AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
